rf_cmd_server: RTL and testbench

RF_CMD_SERVER -- requirements
Module: rf_cmd_server

---
 rtl/rf_cmd_server_if.sv | 34 +++
 rtl/rf_cmd_server.sv | 163 ++++++++++++++++
 tb/tb_rf_cmd_server.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_cmd_server_if.sv
// -----------------------------------------------------------------------------
// rf_cmd_server_if
// Purpose : command/response handshake bundle for rf_cmd_server.
// Signals : cmd_valid/cmd_ready  - command handshake
//           cmd_op               - 00 READ, 01 WRITE, 10 ADD, 11 CLEAR
//           cmd_ra1/cmd_ra2      - read addresses (ra2 used by ADD only)
//           cmd_wa/cmd_wdata     - write address / write data
//           rsp_valid/rsp_ready  - response handshake
//           rsp_data/rsp_err     - response value and error flag
// Modports: master drives commands and consumes responses; slave is the server.
// -----------------------------------------------------------------------------
interface rf_cmd_server_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_ra1;
  logic [4:0]  cmd_ra2;
  logic [4:0]  cmd_wa;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_ra1, cmd_ra2, cmd_wa, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_ra1, cmd_ra2, cmd_wa, cmd_wdata, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/rf_cmd_server.sv
// -----------------------------------------------------------------------------
// rf_cmd_server
// Purpose : 32 x 32-bit register file served through a command/response
//           handshake. Supports READ, WRITE, ADD (reg[wa] = reg[ra1]+reg[ra2])
//           and CLEAR (zero reg1..reg31, one per cycle).
// Ports   : i_clk        - clock, rising edge
//           i_reset      - synchronous active-high reset
//           bus          - rf_cmd_server_if.slave command/response bundle
//           i_test_addr  - debug read address
//           o_test_data  - combinational read of reg[i_test_addr]
//           o_busy       - high whenever the FSM is not in IDLE
// Param   : CLR_ON_RESET - 1: reset zeroes the registers, 0: contents kept
// -----------------------------------------------------------------------------
module rf_cmd_server #(
  parameter bit CLR_ON_RESET = 1'b1
) (
  input  logic           i_clk,
  input  logic           i_reset,
  rf_cmd_server_if.slave bus,
  input  logic [4:0]     i_test_addr,
  output logic [31:0]    o_test_data,
  output logic           o_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_CLR  = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_ADD   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  state_t      r_state;
  logic [1:0]  r_op;
  logic [4:0]  r_ra1;
  logic [4:0]  r_ra2;
  logic [4:0]  r_wa;
  logic [31:0] r_wdata;
  logic [4:0]  r_clr_cnt;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_data;
  logic        r_rsp_err;
  logic        r_busy;

  // reg0 has no storage: it is hard-wired to zero on every read path.
  logic [31:0] r_regs [1:31];

  logic [31:0] w_rd1;
  logic [31:0] w_rd2;
  logic [32:0] w_sum;
  logic        w_wa_zero;
  logic        w_exec_we;
  logic [31:0] w_exec_wdata;
  logic        w_clr_we;

  assign w_rd1        = (r_ra1 == 5'd0) ? 32'd0 : r_regs[r_ra1];
  assign w_rd2        = (r_ra2 == 5'd0) ? 32'd0 : r_regs[r_ra2];
  // 33-bit sum so the carry out of bit 31 is visible for the error flag.
  assign w_sum        = {1'b0, w_rd1} + {1'b0, w_rd2};
  assign w_wa_zero    = (r_wa == 5'd0);
  assign w_exec_we    = (r_state == S_EXEC) && ((r_op == OP_WRITE) || (r_op == OP_ADD));
  assign w_exec_wdata = (r_op == OP_ADD) ? w_sum[31:0] : r_wdata;
  // Counter value 0 is a lead-in cycle; reg1..reg31 are cleared at counts 1..31.
  assign w_clr_we     = (r_state == S_CLR);

  assign bus.cmd_ready = (r_state == S_IDLE) && !i_reset;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_err   = r_rsp_err;
  assign o_busy        = r_busy;
  assign o_test_data   = (i_test_addr == 5'd0) ? 32'd0 : r_regs[i_test_addr];

  // Command FSM: latches commands, sequences EXEC/CLR and holds the response.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 32'd0;
      r_rsp_err   <= 1'b0;
      r_busy      <= 1'b0;
      r_clr_cnt   <= 5'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            r_op      <= bus.cmd_op;
            r_ra1     <= bus.cmd_ra1;
            r_ra2     <= bus.cmd_ra2;
            r_wa      <= bus.cmd_wa;
            r_wdata   <= bus.cmd_wdata;
            r_clr_cnt <= 5'd0;
            r_busy    <= 1'b1;
            r_state   <= (bus.cmd_op == OP_CLEAR) ? S_CLR : S_EXEC;
          end
        end
        S_EXEC: begin
          case (r_op)
            OP_READ: begin
              r_rsp_data <= w_rd1;
              r_rsp_err  <= 1'b0;
            end
            OP_WRITE: begin
              r_rsp_data <= r_wdata;
              r_rsp_err  <= w_wa_zero;
            end
            OP_ADD: begin
              r_rsp_data <= w_sum[31:0];
              r_rsp_err  <= w_wa_zero | w_sum[32];
            end
            default: begin
              r_rsp_data <= 32'd0;
              r_rsp_err  <= 1'b0;
            end
          endcase
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_CLR: begin
          if (r_clr_cnt == 5'd31) begin
            r_rsp_data  <= 32'd31;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_clr_cnt <= r_clr_cnt + 5'd1;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  for (genvar gi = 1; gi < 32; gi++) begin : g_reg
    // Storage for register gi: optional reset clear, CLEAR sweep, EXEC write.
    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        if (CLR_ON_RESET) begin
          r_regs[gi] <= 32'd0;
        end
      end else if (w_clr_we && (r_clr_cnt == 5'(gi))) begin
        r_regs[gi] <= 32'd0;
      end else if (w_exec_we && (r_wa == 5'(gi))) begin
        r_regs[gi] <= w_exec_wdata;
      end
    end
  end

endmodule

// File: tb/tb_rf_cmd_server.sv
`timescale 1ns/1ps
module tb_rf_cmd_server;

  localparam logic [1:0] RD = 2'b00;
  localparam logic [1:0] WR = 2'b01;
  localparam logic [1:0] AD = 2'b10;
  localparam logic [1:0] CL = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst0 = 1'b1;
  logic [4:0]  ta = 5'd7;
  logic [4:0]  ta0 = 5'd0;
  logic [31:0] td;
  logic [31:0] td0;
  logic        busy;
  logic        busy0;

  rf_cmd_server_if ifc ();
  rf_cmd_server_if ifc0 ();

  rf_cmd_server dut (
    .i_clk(clk), .i_reset(rst), .bus(ifc),
    .i_test_addr(ta), .o_test_data(td), .o_busy(busy)
  );

  rf_cmd_server #(.CLR_ON_RESET(1'b0)) dut0 (
    .i_clk(clk), .i_reset(rst0), .bus(ifc0),
    .i_test_addr(ta0), .o_test_data(td0), .o_busy(busy0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mdl [32];
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  bit          rr_rand = 1'b1;
  logic        rr_force = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, {31'd0, act}, {31'd0, exp});
  endtask

  // Reference model: applied at command acceptance, commands are serialised.
  task automatic model(input logic [1:0] op, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] wa, input logic [31:0] wd, output exp_t e);
    logic [32:0] s;
    e.err = 1'b0;
    case (op)
      RD: e.data = mdl[a1];
      WR: begin
        e.data = wd;
        e.err  = (wa == 5'd0);
        if (wa != 5'd0) mdl[wa] = wd;
      end
      AD: begin
        s = {1'b0, mdl[a1]} + {1'b0, mdl[a2]};
        e.data = s[31:0];
        e.err  = (wa == 5'd0) || s[32];
        if (wa != 5'd0) mdl[wa] = s[31:0];
      end
      default: begin
        for (int i = 1; i < 32; i++) mdl[i] = 32'd0;
        e.data = 32'd31;
      end
    endcase
  endtask

  task automatic issue(input logic [1:0] op, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] wa, input logic [31:0] wd);
    exp_t e;
    int   n;
    @(negedge clk);
    ifc.cmd_valid = 1'b1;
    ifc.cmd_op = op; ifc.cmd_ra1 = a1; ifc.cmd_ra2 = a2;
    ifc.cmd_wa = wa; ifc.cmd_wdata = wd;
    n = 0;
    while (!ifc.cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ifc.cmd_ready) begin
      chk("accept_timeout", 32'(n), 32'd0);
      ifc.cmd_valid = 1'b0;
      return;
    end
    model(op, a1, a2, wa, wd, e);
    e.cyc = cyc + ((op == CL) ? 33 : 2);
    q.push_back(e);
    @(posedge clk);
    #1 ifc.cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || ifc.rsp_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk1("drain_timeout", (n >= 500), 1'b0);
  endtask

  task automatic check_td(input logic [4:0] a, input logic [31:0] exp);
    @(negedge clk);
    ta = a;
    #1 chk($sformatf("test_data[%0d]", a), td, exp);
  endtask

  task automatic issue0(input logic [1:0] op, input logic [4:0] wa, input logic [31:0] wd);
    int n;
    @(negedge clk);
    ifc0.cmd_valid = 1'b1; ifc0.cmd_op = op; ifc0.cmd_ra1 = 5'd0;
    ifc0.cmd_ra2 = 5'd0; ifc0.cmd_wa = wa; ifc0.cmd_wdata = wd;
    n = 0;
    while (!ifc0.cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 ifc0.cmd_valid = 1'b0;
    n = 0;
    while (!ifc0.rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("dut0_wr_rsp", ifc0.rsp_data, wd);
  endtask

  // Randomised response back-pressure, or a forced level for directed phases.
  initial begin
    ifc.rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2 ifc.rsp_ready = rr_rand ? ($urandom_range(0, 3) != 0) : rr_force;
    end
  end

  // Monitor: compares every presented response against the scoreboard head.
  initial begin
    logic prev_v;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v = 1'b0;
      end else begin
        if (ifc.rsp_valid) begin
          if (q.size() == 0) begin
            chk("spurious_rsp", 32'd1, 32'd0);
          end else begin
            if (!prev_v) chk("rsp_latency", 32'(cyc), 32'(q[0].cyc));
            chk("rsp_data", ifc.rsp_data, q[0].data);
            chk1("rsp_err", ifc.rsp_err, q[0].err);
            if (ifc.rsp_ready) void'(q.pop_front());
          end
        end
        prev_v = ifc.rsp_valid;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int r;
    int cnt;
    logic [1:0]  op;
    logic [31:0] wd;
    ifc.cmd_valid = 1'b0; ifc.cmd_op = 2'b00; ifc.cmd_ra1 = 5'd0; ifc.cmd_ra2 = 5'd0;
    ifc.cmd_wa = 5'd0; ifc.cmd_wdata = 32'd0;
    ifc0.cmd_valid = 1'b0; ifc0.cmd_op = 2'b00; ifc0.cmd_ra1 = 5'd0; ifc0.cmd_ra2 = 5'd0;
    ifc0.cmd_wa = 5'd0; ifc0.cmd_wdata = 32'd0; ifc0.rsp_ready = 1'b1;
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("rst_cmd_ready", ifc.cmd_ready, 1'b0);
    chk1("rst_rsp_valid", ifc.rsp_valid, 1'b0);
    chk("rst_rsp_data", ifc.rsp_data, 32'd0);
    chk1("rst_rsp_err", ifc.rsp_err, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk("rst_reg7", td, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk1("idle_cmd_ready", ifc.cmd_ready, 1'b1);

    // Basic add
    issue(WR, 5'd0, 5'd0, 5'd1, 32'd5);
    issue(WR, 5'd0, 5'd0, 5'd2, 32'd7);
    issue(AD, 5'd1, 5'd2, 5'd3, 32'd0);
    drain();
    check_td(5'd3, 32'd12);

    // Carry out of bit 31
    issue(WR, 5'd0, 5'd0, 5'd1, 32'hFFFF_FFFF);
    issue(WR, 5'd0, 5'd0, 5'd2, 32'd2);
    issue(AD, 5'd1, 5'd2, 5'd3, 32'd0);
    drain();
    check_td(5'd3, 32'd1);

    // ADD with wa == ra1 uses the old operand
    issue(AD, 5'd3, 5'd3, 5'd3, 32'd0);
    drain();
    check_td(5'd3, 32'd2);

    // Write to reg0 is discarded and flagged
    issue(WR, 5'd0, 5'd0, 5'd0, 32'h0000_DEAD);
    issue(RD, 5'd0, 5'd0, 5'd0, 32'd0);
    drain();
    check_td(5'd0, 32'd0);

    // Back-pressure: response held, commands ignored meanwhile
    rr_rand = 1'b0;
    rr_force = 1'b0;
    issue(RD, 5'd3, 5'd0, 5'd0, 32'd0);
    cnt = 0;
    while (!ifc.rsp_valid && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    ifc.cmd_valid = 1'b1; ifc.cmd_op = WR; ifc.cmd_wa = 5'd5; ifc.cmd_wdata = 32'h0000_0BAD;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk1("hold_cmd_ready", ifc.cmd_ready, 1'b0);
      chk1("hold_rsp_valid", ifc.rsp_valid, 1'b1);
    end
    ifc.cmd_valid = 1'b0;
    rr_force = 1'b1;
    drain();
    rr_rand = 1'b1;
    check_td(5'd5, mdl[5]);

    // Randomised traffic
    for (int k = 0; k < 150; k++) begin
      r  = $urandom_range(0, 29);
      op = (r == 0) ? CL : 2'(r % 3);
      wd = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 15))) : $urandom;
      issue(op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), wd);
    end
    drain();
    for (int a = 0; a < 32; a++) check_td(5'(a), mdl[a]);
    chk1("idle_busy", busy, 1'b0);

    // Full CLEAR
    for (int i = 1; i < 32; i++) issue(WR, 5'd0, 5'd0, 5'(i), 32'h100 + 32'(i));
    issue(CL, 5'd0, 5'd0, 5'd0, 32'd0);
    drain();
    for (int a = 0; a < 32; a++) check_td(5'(a), 32'd0);

    // Reset mid-EXEC abandons the command
    issue(WR, 5'd0, 5'd0, 5'd4, 32'h55);
    rst = 1'b1;
    @(negedge clk);
    chk1("rst_mid_cmd_ready", ifc.cmd_ready, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    q.delete();
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (ifc.rsp_valid) cnt++;
    end
    chk("abort_no_rsp", 32'(cnt), 32'd0);
    chk1("abort_busy", busy, 1'b0);
    check_td(5'd4, 32'd0);

    // CLR_ON_RESET=0: reset 10 cycles into CLEAR leaves it partial
    @(posedge clk);
    #1 rst0 = 1'b0;
    for (int i = 1; i < 32; i++) issue0(WR, 5'(i), 32'h1000 + 32'(i));
    @(negedge clk);
    ifc0.cmd_valid = 1'b1; ifc0.cmd_op = CL;
    cnt = 0;
    while (!ifc0.cmd_ready && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    @(posedge clk);
    #1 ifc0.cmd_valid = 1'b0;
    repeat (11) @(posedge clk);
    #1 rst0 = 1'b1;
    @(posedge clk);
    #1 rst0 = 1'b0;
    @(negedge clk);
    chk1("part_cmd_ready", ifc0.cmd_ready, 1'b1);
    chk1("part_busy", busy0, 1'b0);
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (ifc0.rsp_valid) cnt++;
    end
    chk("part_no_rsp", 32'(cnt), 32'd0);
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      ta0 = 5'(i);
      #1 chk($sformatf("part_reg[%0d]", i), td0, (i <= 10) ? 32'd0 : 32'h1000 + 32'(i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
